// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues word requests, applies static
// predecoded redirects and buffers fetched words in a small circular FIFO toward decode.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_valid_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pd_instr_o,
    input  logic        pd_jal_i,
    input  logic        pd_jalr_i,
    input  logic        pd_branch_i,
    input  logic        pd_fence_i,
    input  logic        pd_valid_i,
    input  logic [31:0] pd_imm_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_pc_o,
    output logic [31:0] inst_instr_o,
    output logic        inst_taken_o,
    output logic        inst_illegal_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_C  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {S_REQ = 2'd0, S_HOLD = 2'd1, S_DRAIN = 2'd2} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   drain_addr_q, drain_addr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]   fifo_pc_q    [DEPTH];
    logic [31:0]   fifo_instr_q [DEPTH];
    logic          fifo_taken_q [DEPTH];
    logic          fifo_ill_q   [DEPTH];
    logic          fire_s, push_s, pop_s, flush_s, taken_s;

    assign imem_valid_o   = rst_ni && ((state_q == S_REQ && count_q < FULL_C) || state_q == S_DRAIN);
    assign imem_addr_o    = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
    assign pd_instr_o     = imem_rdata_i;
    assign inst_valid_o   = (count_q != '0);
    assign inst_pc_o      = fifo_pc_q[rd_ptr_q];
    assign inst_instr_o   = fifo_instr_q[rd_ptr_q];
    assign inst_taken_o   = fifo_taken_q[rd_ptr_q];
    assign inst_illegal_o = fifo_ill_q[rd_ptr_q];
    assign fire_s         = imem_valid_o && imem_ready_i;
    assign pop_s          = inst_valid_o && inst_ready_i;

    // Next-state: redirect overrides everything; a stalled request must finish in DRAIN.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        push_s       = 1'b0;
        flush_s      = 1'b0;
        taken_s      = 1'b0;
        if (redirect_i) begin
            flush_s = 1'b1;
            pc_d    = {redirect_pc_i[31:2], 2'b00};
            if (imem_valid_o && !imem_ready_i) begin
                state_d      = S_DRAIN;
                drain_addr_d = imem_addr_o;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (fire_s) begin
                        push_s = 1'b1;
                        if (!pd_valid_i || pd_jalr_i || pd_fence_i) begin
                            state_d = S_HOLD;
                        end else if (pd_jal_i || (pd_branch_i && pd_imm_i[31])) begin
                            taken_s = 1'b1;
                            pc_d    = pc_q + pd_imm_i;
                        end else begin
                            pc_d = pc_q + 32'd4;
                        end
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_ready_i) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                S_HOLD:  state_d = S_HOLD;
                default: state_d = S_REQ;
            endcase
        end
    end

    // FIFO bookkeeping; a flush resets both pointers so the head is always slot 0 afterwards.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_s) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State, PC and FIFO storage registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            drain_addr_q <= 32'h0000_0000;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]    <= 32'h0000_0000;
                fifo_instr_q[i] <= 32'h0000_0000;
                fifo_taken_q[i] <= 1'b0;
                fifo_ill_q[i]   <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            if (push_s) begin
                fifo_pc_q[wr_ptr_q]    <= pc_q;
                fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
                fifo_taken_q[wr_ptr_q] <= taken_s;
                fifo_ill_q[wr_ptr_q]   <= !pd_valid_i;
            end
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a spec-level model predicts requests and FIFO contents,
// and directed checks pin handshake address sequences and reset values.
module tb_fetch_ctrl;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic        jal, jalr, branch, fence, valid;
        logic [31:0] imm;
    } pd_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic        ill;
    } ent_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        imem_valid, imem_ready, redirect, inst_valid, inst_ready;
    logic        inst_taken, inst_illegal;
    logic [31:0] imem_addr, imem_rdata, pd_instr, inst_pc, inst_instr, redirect_pc;
    pd_t         pcur;

    logic [31:0] mem [logic [31:0]];
    ent_t        sb [$];
    logic [31:0] hs_log [$];
    logic [31:0] exp_log [$];
    int          m_state;
    logic [31:0] m_pc, m_drain;
    logic        s_valid;
    logic [31:0] s_addr;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0000_0013;
    endfunction

    // Toy predecoder: opcode in [6:0], sign-extended immediate in [31:20].
    function automatic pd_t pdec(input logic [31:0] w);
        pd_t p;
        p.jal    = (w[6:0] == 7'h6F);
        p.jalr   = (w[6:0] == 7'h67);
        p.branch = (w[6:0] == 7'h63);
        p.fence  = (w[6:0] == 7'h0F);
        p.valid  = (w[6:0] != 7'h7F);
        p.imm    = {{20{w[31]}}, w[31:20]};
        return p;
    endfunction

    assign imem_rdata = mem_rd(imem_addr);
    assign pcur       = pdec(pd_instr);

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .imem_valid_o(imem_valid), .imem_addr_o(imem_addr),
        .imem_ready_i(imem_ready), .imem_rdata_i(imem_rdata),
        .pd_instr_o(pd_instr),
        .pd_jal_i(pcur.jal), .pd_jalr_i(pcur.jalr), .pd_branch_i(pcur.branch),
        .pd_fence_i(pcur.fence), .pd_valid_i(pcur.valid), .pd_imm_i(pcur.imm),
        .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
        .inst_pc_o(inst_pc), .inst_instr_o(inst_instr),
        .inst_taken_o(inst_taken), .inst_illegal_o(inst_illegal),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic m_valid();
        return rst_n && ((m_state == 0 && sb.size() < DEPTH) || m_state == 2);
    endfunction

    function automatic logic [31:0] m_addr();
        return (m_state == 2) ? m_drain : m_pc;
    endfunction

    // Request seen by the memory this cycle, captured away from the rising edge.
    always @(negedge clk) begin
        s_valid = imem_valid;
        s_addr  = imem_addr;
    end

    // Reference model of the fetch sequence; pushes expected FIFO entries.
    always @(posedge clk) begin
        logic        ev;
        logic [31:0] ea, w;
        pd_t         p;
        ent_t        e;
        if (!rst_n) begin
            m_state = 0;
            m_pc    = 32'h0000_0000;
            m_drain = 32'h0000_0000;
            sb.delete();
        end else begin
            ev = m_valid();
            ea = m_addr();
            if (s_valid && imem_ready) hs_log.push_back(s_addr);
            if (redirect) begin
                sb.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
                if (ev && !imem_ready) begin
                    m_drain = ea;
                    m_state = 2;
                end else begin
                    m_state = 0;
                end
            end else begin
                if (sb.size() != 0 && inst_ready) void'(sb.pop_front());
                if (m_state == 2) begin
                    if (imem_ready) m_state = 0;
                end else if (m_state == 0 && ev && imem_ready) begin
                    w = mem_rd(ea);
                    p = pdec(w);
                    e.pc = m_pc; e.instr = w; e.taken = 1'b0; e.ill = !p.valid;
                    if (!p.valid || p.jalr || p.fence) begin
                        m_state = 1;
                    end else if (p.jal || (p.branch && p.imm[31])) begin
                        e.taken = 1'b1;
                        m_pc = m_pc + p.imm;
                    end else begin
                        m_pc = m_pc + 32'd4;
                    end
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        logic ev;
        @(posedge clk);
        @(negedge clk);
        ev = m_valid();
        check_eq("imem_valid", {31'd0, imem_valid}, {31'd0, ev});
        if (ev) check_eq("imem_addr", imem_addr, m_addr());
        check_eq("pd_instr", pd_instr, imem_rdata);
        check_eq("inst_valid", {31'd0, inst_valid}, {31'd0, sb.size() != 0});
        if (sb.size() != 0) begin
            check_eq("inst_pc", inst_pc, sb[0].pc);
            check_eq("inst_instr", inst_instr, sb[0].instr);
            check_eq("inst_taken", {31'd0, inst_taken}, {31'd0, sb[0].taken});
            check_eq("inst_illegal", {31'd0, inst_illegal}, {31'd0, sb[0].ill});
        end
    endtask

    task automatic do_redirect(input logic [31:0] a);
        redirect    = 1'b1;
        redirect_pc = a;
        tick();
        redirect    = 1'b0;
    endtask

    task automatic check_log();
        check_eq("hs_count", 32'(hs_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < hs_log.size(); i++)
            check_eq("hs_addr", hs_log[i], exp_log[i]);
        hs_log.delete();
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_imem_valid", {31'd0, imem_valid}, 32'd0);
        check_eq("rst_imem_addr", imem_addr, 32'h0000_0000);
        check_eq("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("rst_inst_pc", inst_pc, 32'h0000_0000);
        check_eq("rst_inst_instr", inst_instr, 32'h0000_0000);
        check_eq("rst_inst_flags", {30'd0, inst_taken, inst_illegal}, 32'd0);
    endtask

    initial begin
        imem_ready = 1'b1; inst_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0000_0000;
        mem[32'h10]  = 32'h0400_006F;   // jal +0x40
        mem[32'h50]  = 32'h0080_0063;   // forward branch +8
        mem[32'h54]  = 32'hFF00_0063;   // backward branch -16
        mem[32'h48]  = 32'h0000_0067;   // jalr
        mem[32'h108] = 32'h0000_0067;
        mem[32'h204] = 32'h0000_000F;   // fence
        mem[32'h30C] = 32'h0000_0067;

        rst_n = 1'b0;
        tick(); tick();
        check_reset_outputs();
        rst_n = 1'b1;
        #1;
        check_eq("first_req_valid", {31'd0, imem_valid}, 32'd1);
        check_eq("first_req_addr", imem_addr, 32'h0000_0000);
        repeat (20) tick();
        exp_log = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h50, 32'h54, 32'h44, 32'h48};
        check_log();

        do_redirect(32'h0000_0103);
        repeat (10) tick();
        exp_log = '{32'h100, 32'h104, 32'h108};
        check_log();

        imem_ready = 1'b0;
        do_redirect(32'h0000_0030);
        do_redirect(32'h0000_0200);
        tick(); tick();
        check_eq("drain_valid", {31'd0, imem_valid}, 32'd1);
        check_eq("drain_addr", imem_addr, 32'h0000_0030);
        imem_ready = 1'b1;
        repeat (10) tick();
        exp_log = '{32'h30, 32'h200, 32'h204};
        check_log();

        inst_ready = 1'b0;
        do_redirect(32'h0000_0300);
        repeat (6) tick();
        check_eq("full_no_req", {31'd0, imem_valid}, 32'd0);
        check_eq("full_head_pc", inst_pc, 32'h0000_0300);
        inst_ready = 1'b1;
        repeat (12) tick();
        exp_log = '{32'h300, 32'h304, 32'h308, 32'h30C};
        check_log();

        mem[32'h8] = 32'h0000_007F;     // illegal word
        do_redirect(32'hFFFF_FFF8);
        repeat (10) tick();
        exp_log = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
        check_log();

        rst_n = 1'b0;
        tick(); tick();
        check_reset_outputs();
        rst_n = 1'b1;
        #1;
        check_eq("restart_valid", {31'd0, imem_valid}, 32'd1);
        check_eq("restart_addr", imem_addr, 32'h0000_0000);
        repeat (10) tick();
        exp_log = '{32'h0, 32'h4, 32'h8};
        check_log();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
